risc8_regs_wb: RTL and testbench

Writeback scheduler for the risc8 register file's single write port. Three requesters compete for it: the ALU (byte or word results), the load unit (byte loads) and the pointer-update path (X/Y/Z post-increment/pre-decrement word updates). The block arbitrates between them with valid/ready handshakes, registers the winning write onto the register file's `write`/`write_word`/`d`/`Rd` port, and can optionally zero the register file after reset.

---
 rtl/risc8_pkg.sv | 23 ++
 rtl/risc8_wb_prio.sv | 26 ++
 rtl/risc8_regs_wb.sv | 126 ++++++++++++
 tb/tb_risc8_regs_wb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/risc8_pkg.sv
// Shared risc8 definitions: writeback FSM encoding, requester indices and
// the request record passed from each requester into the write-port mux.
package risc8_pkg;

    localparam int RF_NWORDS = 16;

    localparam int NREQ    = 3;
    localparam int REQ_LD  = 0;
    localparam int REQ_ALU = 1;
    localparam int REQ_PTR = 2;

    typedef enum logic {
        WB_CLEAR = 1'b0,
        WB_RUN   = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic        word;
        logic [5:0]  d;
        logic [15:0] data;
    } wb_req_t;

endpackage

// File: rtl/risc8_wb_prio.sv
// Combinational 3-way picker: ld > alu > ptr, with a starvation override that
// lets a pending ptr request jump the queue. Always grants exactly one lane.
module risc8_wb_prio
    import risc8_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            force_ptr,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (force_ptr && valid[REQ_PTR])
            grant[REQ_PTR] = 1'b1;
        else if (valid[REQ_LD])
            grant[REQ_LD] = 1'b1;
        else if (valid[REQ_ALU])
            grant[REQ_ALU] = 1'b1;
        else if (valid[REQ_PTR])
            grant[REQ_PTR] = 1'b1;
        else
            // idle default parks the grant on ld so a load lands with no wait
            grant[REQ_LD] = 1'b1;
    end

endmodule

// File: rtl/risc8_regs_wb.sv
// Writeback scheduler for the risc8 register file write port.
// Define RISC8_RF_CLEAR_EN to zero the register file after every reset.
module risc8_regs_wb
    import risc8_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int NWORDS     = RF_NWORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic        alu_word,
    input  logic [5:0]  alu_d,
    input  logic [15:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [5:0]  ld_d,
    input  logic [7:0]  ld_data,
    input  logic        ptr_valid,
    output logic        ptr_ready,
    input  logic [5:0]  ptr_d,
    input  logic [15:0] ptr_data,
    output logic        write,
    output logic        write_word,
    output logic [5:0]  d,
    output logic [15:0] Rd,
    output logic        busy,
    output logic        misalign_err
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]   starve;
    logic            run;
    logic [NREQ-1:0] valid, grant, ready;
    logic            xfer;
    wb_req_t         req [NREQ];
    wb_req_t         win;

`ifdef RISC8_RF_CLEAR_EN
    localparam logic [4:0] CNT_LAST = 5'(NWORDS - 1);
    wb_state_t  state;
    logic [4:0] cnt;
    assign run  = (state == WB_RUN);
    assign busy = (state == WB_CLEAR);
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    always_comb begin
        valid          = '0;
        valid[REQ_LD]  = ld_valid;
        valid[REQ_ALU] = alu_valid;
        valid[REQ_PTR] = ptr_valid;

        req[REQ_LD]  = '{word: 1'b0, d: ld_d, data: {8'h00, ld_data}};
        req[REQ_ALU] = '{word: alu_word, d: alu_d,
                         data: alu_word ? alu_data : {8'h00, alu_data[7:0]}};
        req[REQ_PTR] = '{word: 1'b1, d: ptr_d, data: ptr_data};
    end

    risc8_wb_prio u_prio (
        .valid     (valid),
        .force_ptr (starve >= STARVE_LIM),
        .grant     (grant)
    );

    // readies are held low while in reset and while the clear walk owns the port
    assign ready     = (reset && run) ? grant : '0;
    assign ld_ready  = ready[REQ_LD];
    assign alu_ready = ready[REQ_ALU];
    assign ptr_ready = ready[REQ_PTR];
    assign xfer      = |(valid & ready);

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i]) win = req[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            write        <= 1'b0;
            write_word   <= 1'b0;
            d            <= '0;
            Rd           <= '0;
            misalign_err <= 1'b0;
            starve       <= '0;
`ifdef RISC8_RF_CLEAR_EN
            state        <= WB_CLEAR;
            cnt          <= '0;
`endif
        end else begin
`ifdef RISC8_RF_CLEAR_EN
            if (state == WB_CLEAR) begin
                write      <= 1'b1;
                write_word <= 1'b1;
                d          <= {cnt, 1'b0};
                Rd         <= '0;
                if (cnt == CNT_LAST)
                    state <= WB_RUN;
                else
                    cnt <= cnt + 5'd1;
            end else
`endif
            begin
                write <= xfer;
                if (xfer) begin
                    write_word <= win.word;
                    d          <= win.word ? {win.d[5:1], 1'b0} : win.d;
                    Rd         <= win.data;
                    if (win.word && win.d[0])
                        misalign_err <= 1'b1;
                end
                if (!ptr_valid || ptr_ready)
                    starve <= '0;
                else if (starve < STARVE_LIM)
                    starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_risc8_regs_wb.sv
// Directed bench for risc8_regs_wb: clear walk, arbitration, starvation
// override, misaligned word writes, idle hold and mid-sequence reset.
module tb_risc8_regs_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, alu_word;
    logic [5:0]  alu_d;
    logic [15:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [5:0]  ld_d;
    logic [7:0]  ld_data;
    logic        ptr_valid, ptr_ready;
    logic [5:0]  ptr_d;
    logic [15:0] ptr_data;
    logic        write, write_word, busy, misalign_err;
    logic [5:0]  d;
    logic [15:0] Rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc8_regs_wb #(.STARVE_MAX(3), .NWORDS(16)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_word(alu_word),
        .alu_d(alu_d), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_d(ld_d), .ld_data(ld_data),
        .ptr_valid(ptr_valid), .ptr_ready(ptr_ready), .ptr_d(ptr_d), .ptr_data(ptr_data),
        .write(write), .write_word(write_word), .d(d), .Rd(Rd),
        .busy(busy), .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic w, input logic ww,
                           input logic [5:0] ed, input logic [15:0] erd);
        chk({tag, ".write"}, 16'(write), 16'(w));
        chk({tag, ".write_word"}, 16'(write_word), 16'(ww));
        chk({tag, ".d"}, 16'(d), 16'(ed));
        chk({tag, ".Rd"}, Rd, erd);
    endtask

    task automatic chk_rdy(input string tag, input logic l, input logic a, input logic p);
        chk({tag, ".ld_ready"}, 16'(ld_ready), 16'(l));
        chk({tag, ".alu_ready"}, 16'(alu_ready), 16'(a));
        chk({tag, ".ptr_ready"}, 16'(ptr_ready), 16'(p));
    endtask

`ifdef RISC8_RF_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    initial begin
        reset = 1'b0;
        alu_valid = 0; alu_word = 0; alu_d = 0; alu_data = 0;
        ld_valid = 1; ld_d = 0; ld_data = 0;
        ptr_valid = 1; ptr_d = 0; ptr_data = 0;

        // reset state, with valids raised to prove readies stay low
        step(); step();
        chk_out("rst", 0, 0, 6'd0, 16'h0000);
        chk("rst.misalign", 16'(misalign_err), 16'd0);
        chk("rst.busy", 16'(busy), 16'(BUSY_RST));
        chk_rdy("rst", 0, 0, 0);
        ld_valid = 0; ptr_valid = 0;

        reset = 1'b1;
        #1;
`ifdef RISC8_RF_CLEAR_EN
        chk("clr.c1.busy", 16'(busy), 16'd1);
        chk_rdy("clr.c1", 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            chk_out($sformatf("clr.w%0d", k), 1, 1, 6'(2 * k), 16'h0000);
            chk($sformatf("clr.w%0d.busy", k), 16'(busy), 16'(k < 15));
        end
        chk_rdy("clr.done", 1, 0, 0);
        step();
        chk("clr.idle.write", 16'(write), 16'd0);
`else
        chk("run.c1.busy", 16'(busy), 16'd0);
        chk_rdy("run.c1", 1, 0, 0);
        chk("run.c1.write", 16'(write), 16'd0);
`endif

        // ld and alu together: ld first, alu the very next cycle
        ld_valid = 1; ld_d = 6'd5; ld_data = 8'hA5;
        alu_valid = 1; alu_word = 1; alu_d = 6'd6; alu_data = 16'h1234;
        #1 chk_rdy("la.c0", 1, 0, 0);
        step();
        chk_out("la.ld", 1, 0, 6'd5, 16'h00A5);
        ld_valid = 0;
        #1 chk_rdy("la.c1", 0, 1, 0);
        step();
        chk_out("la.alu", 1, 1, 6'd6, 16'h1234);
        alu_valid = 0;

        // idle: write low, d/Rd hold
        for (int k = 0; k < 5; k++) begin
            step();
            chk_out($sformatf("idle%0d", k), 0, 1, 6'd6, 16'h1234);
        end

        // ptr starved behind continuous ld, forced on the 4th cycle
        ld_valid = 1; ld_d = 6'd3; ld_data = 8'h11;
        ptr_valid = 1; ptr_d = 6'd26; ptr_data = 16'hBEEF;
        for (int k = 1; k <= 3; k++) begin
            #1 chk_rdy($sformatf("starve.c%0d", k), 1, 0, 0);
            step();
            chk_out($sformatf("starve.o%0d", k), 1, 0, 6'd3, 16'h0011);
        end
        #1 chk_rdy("starve.c4", 0, 0, 1);
        step();
        chk_out("starve.ptr", 1, 1, 6'd26, 16'hBEEF);
        ptr_valid = 0;
        #1 chk_rdy("starve.after", 1, 0, 0);
        step();
        chk_out("starve.ld", 1, 0, 6'd3, 16'h0011);
        chk("starve.misalign", 16'(misalign_err), 16'd0);
        ld_valid = 0;

        // byte alu write to odd address is legal; high byte dropped
        alu_valid = 1; alu_word = 0; alu_d = 6'd9; alu_data = 16'hFF77;
        #1 chk_rdy("ab.c0", 0, 1, 0);
        step();
        chk_out("ab", 1, 0, 6'd9, 16'h0077);
        chk("ab.misalign", 16'(misalign_err), 16'd0);

        // misaligned word write: d forced even, sticky error
        alu_word = 1; alu_d = 6'd7; alu_data = 16'h5A5A;
        step();
        chk_out("mis", 1, 1, 6'd6, 16'h5A5A);
        chk("mis.err", 16'(misalign_err), 16'd1);
        alu_valid = 0;
        step(); step();
        chk("mis.sticky", 16'(misalign_err), 16'd1);
        chk("mis.idle.write", 16'(write), 16'd0);

        // reset mid-run returns everything to reset values
        reset = 1'b0;
        step();
        chk_out("rst2", 0, 0, 6'd0, 16'h0000);
        chk("rst2.misalign", 16'(misalign_err), 16'd0);
        chk("rst2.busy", 16'(busy), 16'(BUSY_RST));
        chk_rdy("rst2", 0, 0, 0);
        reset = 1'b1;
        #1;
`ifdef RISC8_RF_CLEAR_EN
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("clr2.w%0d.d", k), 16'(d), 16'(2 * k));
        end
        // word 9 is being issued now; abort it
        reset = 1'b0;
        step();
        chk_out("rst3", 0, 0, 6'd0, 16'h0000);
        chk("rst3.busy", 16'(busy), 16'd1);
        chk_rdy("rst3", 0, 0, 0);
        reset = 1'b1;
        step();
        chk_out("clr3.w0", 1, 1, 6'd0, 16'h0000);
`else
        chk_rdy("rst2.run", 1, 0, 0);
        step();
        chk("rst2.run.write", 16'(write), 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
